// File: rtl/sum_arbiter.sv
// sum_arbiter
// Round-robin front end for a single iterative summation engine that
// computes sum(i, i = 1..N) with one addition per clock. Requesters hold
// a request level and present a 4-bit N. One requester is granted at a
// time. Its job runs to completion, and the 7-bit result is returned
// tagged with the winner's index.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-requester request level, held until acked
//   n_in       packed N values; requester i uses bits [4i+3:4i]
//   ack        one-hot, one-cycle pulse marking the accepted requester
//   busy       high whenever the engine is not idle
//   sum_out    result of the last completed job, held until the next one
//   sum_id     index of the requester that owns sum_out
//   sum_valid  one-cycle pulse when sum_out/sum_id update
module sum_arbiter #(
    parameter int IDW = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2**IDW-1:0]     req,
    input  logic [4*(2**IDW)-1:0] n_in,
    output logic [2**IDW-1:0]     ack,
    output logic                  busy,
    output logic [6:0]            sum_out,
    output logic [IDW-1:0]        sum_id,
    output logic                  sum_valid
);

    localparam int NREQ = 2**IDW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic [6:0]     sum;
    logic [3:0]     count;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic [3:0]     win_n;

    // Search upward from the pointer; IDW-bit addition wraps modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr + IDW'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_n = n_in[{win, 2'b00} +: 4];

    // busy decodes the state register only, so it has no path from req/n_in.
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            sum       <= '0;
            count     <= '0;
            ack       <= '0;
            sum_out   <= '0;
            sum_id    <= '0;
            sum_valid <= 1'b0;
        end else begin
            ack       <= '0;
            sum_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        idx   <= win;
                        // sum starts at N, so the remaining terms are N-1 .. 1.
                        sum   <= {3'b000, win_n};
                        count <= (win_n == 4'd0) ? 4'd0 : win_n - 4'd1;
                        ack   <= NREQ'(1) << win;
                        ptr   <= win + IDW'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (count != 4'd0) begin
                        sum   <= sum + {3'b000, count};
                        count <= count - 4'd1;
                    end else begin
                        sum_out   <= sum;
                        sum_id    <= idx;
                        sum_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_arbiter.md
# sum_arbiter

Round-robin scheduler that shares one iterative summation engine (sum of i for i = 1..N, one addition per clock) among several requesters. Each requester presents a 4-bit N and holds a request. The block grants one requester at a time, loads and sequences the accumulate/count-down datapath, and returns the 7-bit result tagged with the winner's index. It sits between the client blocks and the arithmetic core, and is the only owner of that core.

## Interface
- IDW, 2, requester index width; number of requesters NREQ = 2**IDW
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level; held high until acked
- n_in  input  4*NREQ  packed N values; requester i uses bits [4i+3:4i]
- ack  output  NREQ  one-hot, one-cycle pulse marking the accepted requester
- busy  output  1  high whenever state is not IDLE
- sum_out  output  7  result of the last completed job; holds until the next completion
- sum_id  output  IDW  index of the requester that owns sum_out
- sum_valid  output  1  one-cycle pulse when sum_out/sum_id update

## Operation
- State machine states: IDLE, ACCUM, DONE. Reset enters IDLE.
- Reset values: ack=0, busy=0, sum_out=0, sum_id=0, sum_valid=0, round-robin pointer=0, internal sum and count = 0.
- **IDLE:** if any req bit is high at a clock edge, choose the winner:
  - The winner is the first set bit, searching upward from the pointer and wrapping modulo NREQ.
  - Latch the winner's index and N. Load sum <= N and count <= N-1, except when N=0, which loads count <= 0.
  - Register ack[winner]=1 for exactly the next cycle.
  - Set pointer <= winner+1 mod NREQ, then go to ACCUM.
  - If no req bit is set, stay in IDLE and leave the pointer unchanged.
- **ACCUM:** at each edge:
  - If count != 0: sum <= sum + count and count <= count - 1.
  - If count == 0: register sum_out <= sum, sum_id <= latched index, sum_valid <= 1, and go to DONE.
- **DONE:** sum_valid is high for this single cycle. Go to IDLE at the next edge.
- req and n_in are sampled only at the accepting edge in IDLE. Changes during ACCUM or DONE are ignored.
- A requester drops req in the cycle its ack is high. If req is still high when the block is next in IDLE, it is treated as a new request.
- A req that rises and falls without an ack is lost; no request is queued.
- Arithmetic is unsigned. The maximum result is 15*16/2 = 120, which fits 7 bits, so overflow cannot occur. sum_out equals N*(N+1)/2 for every N in 0..15.
- Reset asserted in any state takes effect at that edge:
  - The job is aborted and no sum_valid is produced.
  - The pointer returns to 0.
  - ack is cleared, even mid-pulse.

## Timing
- Define the accepting edge as edge k.
- ack is high in cycle k..k+1. busy is high from edge k until the return to IDLE.
- sum_valid is high in the cycle after edge k + max(N,1).
  - N=0 and N=1: sum_valid follows edge k+1.
  - N=15: sum_valid follows edge k+15.
- State returns to IDLE at edge k + max(N,1) + 1. The next acceptance is possible at edge k + max(N,1) + 2, giving a job period of max(N,1) + 2 cycles.
- ack and sum_valid never overlap.
- Only one job is in flight at a time.
- Outputs are registered with no combinational path from req or n_in to any output.

## Test plan
- Single job: reset, then req[0]=1 with N=4 → ack=0001 for one cycle; sum_valid exactly 4 cycles after the accepting edge with sum_out=10, sum_id=0; busy low 2 cycles after that sum_valid edge.
- Boundaries: jobs with N=0, 1, 15 on requester 2 → sum_out = 0, 1, 120 respectively, with sum_valid latency 1, 1, 15.
- Round robin: all four req held high, each with N=2, re-asserted after each ack → grant order 0,1,2,3,0; each result is 3 with sum_id matching the grant order.
- Pointer wrap and skipping: after granting 3, only req[1] and req[3] are high → req[1] wins and the pointer becomes 2. Next, only req[0] is high → req[0] wins.
- Input changes ignored: during ACCUM of an N=5 job, toggle n_in and raise another req → result is still 15 and the new req is granted only after return to IDLE.
- Reset mid-job: assert reset 3 cycles into an N=12 job → no sum_valid; all outputs return to reset values next cycle; a following N=3 job on requester 0 returns 6.
